// File: rtl/icon_txq.sv
// Per-EU transmit queue: in-order FIFO of ALPU results routed to the local x-cache port or the interconnect.
// Optional same-cycle bypass on an empty queue when ICON_TXQ_BYPASS_EN is defined.
package pkg_dtypes;
    localparam int unsigned LOG2_NUM_ALPU = 2;
    localparam int unsigned LOG2_NUM_REG  = 3;
    localparam int unsigned DATA_W        = 16;

    typedef logic [LOG2_NUM_REG-1:0] type_alpu_local_addr;
    typedef logic [DATA_W-1:0]       type_exec_unit_data;

    typedef struct packed {
        logic [LOG2_NUM_ALPU-1:0] eu_idx;
        type_alpu_local_addr      reg_idx;
    } type_opd_addr;

    typedef struct packed {
        type_opd_addr       opd_addr;
        type_exec_unit_data opd_data;
        logic               opx;
        logic               opd_valid;
    } type_alpu_channel_tx;

    typedef struct packed {
        type_opd_addr       addr;
        type_exec_unit_data data;
        logic               valid;
    } type_icon_tx_channel;

    typedef struct packed {
        logic ready;
    } type_icon_rx_channel;
endpackage

module icon_txq
    import pkg_dtypes::*;
#(
    parameter int unsigned              DEPTH        = 4,
    parameter logic [LOG2_NUM_ALPU-1:0] LOCAL_EU_IDX = '0
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  type_alpu_channel_tx           i_alpu_tx,
    output logic                          o_alpu_ready,
    output logic                          o_local_valid,
    output type_alpu_local_addr           o_local_addr,
    output type_exec_unit_data            o_local_data,
    output logic                          o_local_opx,
    input  logic                          i_local_ready,
    output type_icon_tx_channel           o_icon_tx,
    output logic                          o_icon_opx,
    input  type_icon_rx_channel           i_icon_rx,
    output logic [$clog2(DEPTH):0]        o_count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        type_opd_addr       addr;
        type_exec_unit_data data;
        logic               opx;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    entry_t          in_entry;
    entry_t          head;
    logic            head_valid;
    logic            is_local;
    logic            fire;
    logic            push;
    logic            pop;
    logic            not_full;
    logic            not_empty;
`ifdef ICON_TXQ_BYPASS_EN
    logic            bypass;
`endif

    assign in_entry  = '{addr: i_alpu_tx.opd_addr, data: i_alpu_tx.opd_data, opx: i_alpu_tx.opx};
    assign not_full  = (count != CW'(DEPTH));
    assign not_empty = (count != CW'(0));

    // Head selection; with bypass an empty queue presents the incoming entry directly
    always_comb begin
        head       = mem[rd_ptr];
        head_valid = not_empty;
`ifdef ICON_TXQ_BYPASS_EN
        bypass     = !not_empty && i_alpu_tx.opd_valid;
        if (bypass) begin
            head       = in_entry;
            head_valid = 1'b1;
        end
`endif
    end

    assign is_local = (head.addr.eu_idx == LOCAL_EU_IDX);
    assign fire     = head_valid && (is_local ? i_local_ready : i_icon_rx.ready);
    assign pop      = fire && not_empty;
`ifdef ICON_TXQ_BYPASS_EN
    assign push     = i_alpu_tx.opd_valid && not_full && !(bypass && fire);
`else
    assign push     = i_alpu_tx.opd_valid && not_full;
`endif

    // Pointer and occupancy state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is intentionally left uncleared by reset
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    assign o_alpu_ready    = not_full;
    assign o_local_valid   = head_valid && is_local;
    assign o_local_addr    = head.addr.reg_idx;
    assign o_local_data    = head.data;
    assign o_local_opx     = head.opx;
    assign o_icon_tx.addr  = head.addr;
    assign o_icon_tx.data  = head.data;
    assign o_icon_tx.valid = head_valid && !is_local;
    assign o_icon_opx      = head.opx;
    assign o_count         = count;
endmodule

// File: tb/tb_icon_txq.sv
// Bench for icon_txq: queue-based reference model compared every cycle, plus directed literal checks.
// Honours ICON_TXQ_BYPASS_EN in both the model and the directed vectors.
module tb_icon_txq;
    import pkg_dtypes::*;

    localparam int unsigned DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    type_alpu_channel_tx in_tx = '0;
    logic                local_ready = 1'b0;
    type_icon_rx_channel icon_rx = '0;

    logic                alpu_ready;
    logic                local_valid;
    type_alpu_local_addr local_addr;
    type_exec_unit_data  local_data;
    logic                local_opx;
    type_icon_tx_channel icon_tx;
    logic                icon_opx;
    logic [2:0]          count;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    type_alpu_channel_tx mq[$];
    logic [15:0]         popped[$];

    icon_txq #(.DEPTH(DEPTH), .LOCAL_EU_IDX(2'd0)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_alpu_tx    (in_tx),
        .o_alpu_ready (alpu_ready),
        .o_local_valid(local_valid),
        .o_local_addr (local_addr),
        .o_local_data (local_data),
        .o_local_opx  (local_opx),
        .i_local_ready(local_ready),
        .o_icon_tx    (icon_tx),
        .o_icon_opx   (icon_opx),
        .i_icon_rx    (icon_rx),
        .o_count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic type_alpu_channel_tx mk(input int eu, input int ri, input int d, input bit x);
        type_alpu_channel_tx t;
        t.opd_addr.eu_idx  = 2'(eu);
        t.opd_addr.reg_idx = 3'(ri);
        t.opd_data         = 16'(d);
        t.opx              = x;
        t.opd_valid        = 1'b1;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO queue; outputs checked, then next state derived from current inputs
    always @(negedge clk) begin
        if (en) begin
            int n;
            bit has, byp, loc, pop, pushok;
            type_alpu_channel_tx h;
            n   = mq.size();
            has = (n != 0);
            byp = 1'b0;
            h   = has ? mq[0] : '0;
`ifdef ICON_TXQ_BYPASS_EN
            if (!has && in_tx.opd_valid) begin
                has = 1'b1;
                byp = 1'b1;
                h   = in_tx;
            end
`endif
            loc = has && (h.opd_addr.eu_idx == 2'd0);
            chk("m_count", 32'(count), 32'(n));
            chk("m_alpu_ready", 32'(alpu_ready), 32'(n != DEPTH));
            chk("m_local_valid", 32'(local_valid), 32'(loc));
            chk("m_icon_valid", 32'(icon_tx.valid), 32'(has && !loc));
            if (loc) begin
                chk("m_local_addr", 32'(local_addr), 32'(h.opd_addr.reg_idx));
                chk("m_local_data", 32'(local_data), 32'(h.opd_data));
                chk("m_local_opx", 32'(local_opx), 32'(h.opx));
            end else if (has) begin
                chk("m_icon_addr", 32'(icon_tx.addr), 32'(h.opd_addr));
                chk("m_icon_data", 32'(icon_tx.data), 32'(h.opd_data));
                chk("m_icon_opx", 32'(icon_opx), 32'(h.opx));
            end
            if (rst) begin
                mq.delete();
            end else begin
                pop    = has && (loc ? local_ready : icon_rx.ready);
                pushok = in_tx.opd_valid && (n != DEPTH);
                if (pop) popped.push_back(loc ? local_data : icon_tx.data);
                if (!(byp && pop)) begin
                    if (pop && n != 0) void'(mq.pop_front());
                    if (pushok) mq.push_back(in_tx);
                end
            end
        end
    end

    initial begin
        step();
        step();
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(alpu_ready), 32'd1);
        chk("rst_valids", 32'({local_valid, icon_tx.valid}), 32'd0);

        // Single foreign entry
        step();
        in_tx = mk(1, 3, 16'hA5, 1'b1);
        step();
        in_tx = '0;
        @(negedge clk);
        chk("f_icon_valid", 32'(icon_tx.valid), 32'd1);
        chk("f_icon_addr", 32'(icon_tx.addr), 32'h0B);
        chk("f_icon_data", 32'(icon_tx.data), 32'hA5);
        chk("f_icon_opx", 32'(icon_opx), 32'd1);
        chk("f_local_valid", 32'(local_valid), 32'd0);
        step();
        icon_rx.ready = 1'b1;
        step();
        icon_rx.ready = 1'b0;
        @(negedge clk);
        chk("f_count_after_pop", 32'(count), 32'd0);

        // Fill to DEPTH with both readies low, then drain mixed entries in order
        step();
        for (int i = 0; i < 4; i++) begin
            in_tx = mk(i % 2, i, 16'h10 + i, i % 2);
            step();
        end
        in_tx = mk(1, 7, 16'h99, 1'b0);
        @(negedge clk);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(alpu_ready), 32'd0);
        step();
        in_tx = '0;
        local_ready = 1'b1;
        icon_rx.ready = 1'b1;
        @(negedge clk);
        chk("full_fifth_ignored", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i % 2 == 0) chk("drain_local", 32'(local_data), 32'(16'h10 + i));
            else            chk("drain_icon", 32'(icon_tx.data), 32'(16'h10 + i));
            step();
        end
        @(negedge clk);
        chk("drain_count", 32'(count), 32'd0);
        step();
        icon_rx.ready = 1'b0;

        // Foreign head blocks a later local entry
        in_tx = mk(0, 1, 16'h20, 1'b0);
        step();
        in_tx = mk(1, 2, 16'h21, 1'b1);
        step();
        in_tx = mk(0, 4, 16'h22, 1'b0);
        step();
        in_tx = '0;
        step();
        @(negedge clk);
        chk("blk_count", 32'(count), 32'd2);
        chk("blk_local_valid", 32'(local_valid), 32'd0);
        chk("blk_icon_data", 32'(icon_tx.data), 32'h21);
        step();
        @(negedge clk);
        chk("blk_count_hold", 32'(count), 32'd2);
        step();
        icon_rx.ready = 1'b1;
        step();
        @(negedge clk);
        chk("blk_local_next", 32'(local_data), 32'h22);
        chk("blk_count1", 32'(count), 32'd1);
        step();
        @(negedge clk);
        chk("blk_count0", 32'(count), 32'd0);
        step();
        icon_rx.ready = 1'b0;
        local_ready = 1'b0;

        // Sustained push+pop across pointer wrap
        in_tx = mk(1, 0, 0, 1'b0);
        step();
        in_tx = mk(1, 1, 1, 1'b0);
        step();
        popped.delete();
        icon_rx.ready = 1'b1;
        for (int d = 2; d < 10; d++) begin
            in_tx = mk(1, d % 8, d, 1'b0);
            @(negedge clk);
            chk("sus_count", 32'(count), 32'd2);
            step();
        end
        in_tx = '0;
        step();
        step();
        @(negedge clk);
        chk("sus_count_end", 32'(count), 32'd0);
        chk("sus_popped_n", 32'(popped.size()), 32'd10);
        for (int k = 0; k < 10; k++)
            if (k < popped.size()) chk("sus_order", 32'(popped[k]), 32'(k));
        step();
        icon_rx.ready = 1'b0;

        // Reset mid-transfer
        for (int i = 0; i < 3; i++) begin
            in_tx = mk(1, i, 16'h30 + i, 1'b0);
            step();
        end
        in_tx = '0;
        @(negedge clk);
        chk("mid_count3", 32'(count), 32'd3);
        step();
        icon_rx.ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        icon_rx.ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valids", 32'({local_valid, icon_tx.valid}), 32'd0);
        chk("mid_rst_ready", 32'(alpu_ready), 32'd1);
        step();
        in_tx = mk(0, 5, 16'h5A, 1'b1);
        step();
        in_tx = '0;
        @(negedge clk);
        chk("post_rst_valid", 32'(local_valid), 32'd1);
        chk("post_rst_data", 32'(local_data), 32'h5A);
        chk("post_rst_addr", 32'(local_addr), 32'd5);
        step();
        local_ready = 1'b1;
        step();
        local_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_drained", 32'(count), 32'd0);

`ifdef ICON_TXQ_BYPASS_EN
        // Same-cycle bypass on an empty queue
        step();
        local_ready = 1'b1;
        in_tx = mk(0, 6, 16'h66, 1'b0);
        @(negedge clk);
        chk("byp_valid", 32'(local_valid), 32'd1);
        chk("byp_data", 32'(local_data), 32'h66);
        chk("byp_count", 32'(count), 32'd0);
        step();
        in_tx = '0;
        @(negedge clk);
        chk("byp_count_after", 32'(count), 32'd0);
        chk("byp_valid_after", 32'(local_valid), 32'd0);
`endif

        step();
        en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
